// File: rtl/cr_fifo_drain_axis.sv
// Drains a 1-cycle-latency FIFO into an AXI-Stream master, framing PKT_LEN words per packet.
// Optional CR_DRAIN_CHECKSUM_EN appends a 16-bit sum beat (carrying tlast) after each packet.
module cr_fifo_drain_axis #(
  parameter int PKT_LEN = 16
) (
  input  logic        clk,
  input  logic        reset_p,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_underflow,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] pkt_count,
  output logic        err_underflow
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  logic [15:0] mem_q [2];
  logic [15:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic        inflight_q, inflight_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        err_q, err_d;

  logic        in_data_s;
  logic        hs_s;
  logic        data_hs_s;
  logic        last_hs_s;
  logic        pkt_inc_s;
  logic        push_s;
  logic        pop_s;
  logic        wr_idx_s;
  logic [1:0]  cnt_after_pop_s;
  logic [15:0] head_s;
  logic        buf_valid_s;

`ifdef CR_DRAIN_CHECKSUM_EN
  typedef enum logic [0:0] {
    ST_DATA = 1'b0,
    ST_CSUM = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic        csum_hs_s;
`endif

  assign head_s      = mem_q[rd_ptr_q];
  assign buf_valid_s = (buf_cnt_q != 2'd0);
  assign hs_s        = m_tvalid & m_tready;
  assign data_hs_s   = hs_s & in_data_s;
  assign last_hs_s   = data_hs_s & (wcnt_q == LAST_IDX);
  assign pop_s       = data_hs_s;
  // A read issued last cycle always lands in the buffer; the issue rule leaves room for it.
  assign push_s      = inflight_q;
  assign wr_idx_s    = rd_ptr_q ^ buf_cnt_q[0];

`ifdef CR_DRAIN_CHECKSUM_EN
  assign in_data_s = (state_q == ST_DATA);
  assign csum_hs_s = hs_s & (state_q == ST_CSUM);
  assign pkt_inc_s = csum_hs_s;
  assign m_tvalid  = in_data_s ? buf_valid_s : 1'b1;
  assign m_tdata   = in_data_s ? head_s : sum_q;
  assign m_tlast   = (state_q == ST_CSUM);
`else
  assign in_data_s = 1'b1;
  assign pkt_inc_s = last_hs_s;
  assign m_tvalid  = buf_valid_s;
  assign m_tdata   = head_s;
  assign m_tlast   = buf_valid_s & (wcnt_q == LAST_IDX);
`endif

  assign pkt_count     = pkt_cnt_q;
  assign err_underflow = err_q;

  // Read issue: only when the buffer can absorb this read plus any read already in flight.
  always_comb begin
    cnt_after_pop_s = buf_cnt_q - {1'b0, pop_s};
    if (!fifo_empty && !reset_p && in_data_s &&
        ((3'(cnt_after_pop_s) + 3'(inflight_q) + 3'd1) <= 3'd2)) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
    inflight_d = fifo_rd_en;
  end

  // Skid buffer: capture on push, advance head on pop, occupancy update.
  always_comb begin
    mem_d[0]  = mem_q[0];
    mem_d[1]  = mem_q[1];
    rd_ptr_d  = rd_ptr_q;
    buf_cnt_d = buf_cnt_q;
    if (push_s) begin
      mem_d[wr_idx_s] = fifo_dout;
    end else begin
      mem_d[wr_idx_s] = mem_q[wr_idx_s];
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  // Word index, packet counter and sticky underflow flag.
  always_comb begin
    wcnt_d    = wcnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q | fifo_underflow;
    if (last_hs_s) begin
      wcnt_d = 8'd0;
    end else if (data_hs_s) begin
      wcnt_d = wcnt_q + 8'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
    if (pkt_inc_s) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      mem_q[0]   <= 16'd0;
      mem_q[1]   <= 16'd0;
      rd_ptr_q   <= 1'b0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      wcnt_q     <= 8'd0;
      pkt_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
      wcnt_q     <= wcnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef CR_DRAIN_CHECKSUM_EN
  // Checksum FSM: accumulate data beats, then emit the sum as the closing beat.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    case (state_q)
      ST_DATA: begin
        if (last_hs_s) begin
          state_d = ST_CSUM;
          sum_d   = sum_q + head_s;
        end else if (data_hs_s) begin
          state_d = ST_DATA;
          sum_d   = sum_q + head_s;
        end else begin
          state_d = ST_DATA;
          sum_d   = sum_q;
        end
      end
      ST_CSUM: begin
        if (csum_hs_s) begin
          state_d = ST_DATA;
          sum_d   = 16'd0;
        end else begin
          state_d = ST_CSUM;
          sum_d   = sum_q;
        end
      end
      default: begin
        state_d = ST_DATA;
        sum_d   = 16'd0;
      end
    endcase
  end

  // Checksum FSM state register.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= ST_DATA;
      sum_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end
`endif

endmodule
